// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM state, funct3 width codes and byte-enable helpers for the load/store unit.
package lsu_pkg;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} lsu_state_e;
   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;
   function automatic logic is_byte(input logic [2:0] f3);
      return f3 == LSU_B || f3 == LSU_BU;
   endfunction
   function automatic logic is_half(input logic [2:0] f3);
      return f3 == LSU_H || f3 == LSU_HU;
   endfunction
   // Unknown width codes fall through to a full word.
   function automatic logic [3:0] lsu_be(input logic [2:0] f3, input logic [1:0] off);
      return is_byte(f3) ? 4'b0001 << off : is_half(f3) ? 4'b0011 << off : 4'b1111;
   endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables, store-lane replication, misalignment check and load extraction/extension.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        i_st_f3,
   input  logic [1:0]        i_st_off,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [3:0]        o_be,
   output logic [DATA_W-1:0] o_wdata,
   output logic              o_misaligned,
   input  logic [2:0]        i_ld_f3,
   input  logic [1:0]        i_ld_off,
   input  logic [DATA_W-1:0] i_rdata,
   output logic [DATA_W-1:0] o_ldata
);
   logic [DATA_W-1:0] w_shift;
   assign w_shift      = i_rdata >> {i_ld_off, 3'b000};
   assign o_be         = lsu_be(i_st_f3, i_st_off);
   assign o_misaligned = is_half(i_st_f3) ? i_st_off[0] : !is_byte(i_st_f3) && i_st_off != 2'b00;
   assign o_wdata      = is_byte(i_st_f3) ? {4{i_wdata[7:0]}} :
                         is_half(i_st_f3) ? {2{i_wdata[15:0]}} : i_wdata;
   assign o_ldata      = i_ld_f3 == LSU_B  ? {{(DATA_W-8){w_shift[7]}}, w_shift[7:0]} :
                         i_ld_f3 == LSU_BU ? {{(DATA_W-8){1'b0}}, w_shift[7:0]} :
                         i_ld_f3 == LSU_H  ? {{(DATA_W-16){w_shift[15]}}, w_shift[15:0]} :
                         i_ld_f3 == LSU_HU ? {{(DATA_W-16){1'b0}}, w_shift[15:0]} : i_rdata;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store FSM driving a req/gnt/rvalid memory port, stalling the core until the access
// completes, with misalignment detection and a gnt/rvalid timeout watchdog.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [2:0]        funct3_i,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_be_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_o,
   output logic [DATA_W-1:0] load_data_o,
   output logic              done_o,
   output logic              misaligned_o,
   output logic              fault_o
);
   localparam int CW = $clog2(TIMEOUT + 1);
   lsu_state_e        r_state, w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        r_be;
   logic [DATA_W-1:0] r_wdata, r_load;
   logic              r_we;
   logic [2:0]        r_f3;
   logic [CW-1:0]     r_cnt;
   logic              w_acc, w_mis, w_busy, w_to;
   logic [3:0]        w_be;
   logic [DATA_W-1:0] w_wdata, w_ldata;
   assign w_acc  = mem_read_i | mem_write_i;
   assign w_busy = r_state == S_REQ || r_state == S_RESP;
   assign w_to   = w_busy && r_cnt == CW'(TIMEOUT);
   lsu_align #(.DATA_W(DATA_W)) u_align (
      .i_st_f3(funct3_i), .i_st_off(addr_i[1:0]), .i_wdata(wdata_i),
      .o_be(w_be), .o_wdata(w_wdata), .o_misaligned(w_mis),
      .i_ld_f3(r_f3), .i_ld_off(r_addr[1:0]), .i_rdata(mem_rdata_i), .o_ldata(w_ldata)
   );
   always_ff @(posedge clk)
      r_state <= rst ? S_IDLE : w_next;
   always_comb
      w_next = w_to                ? S_IDLE :
               r_state == S_IDLE   ? (w_acc && !w_mis ? S_REQ : S_IDLE) :
               r_state == S_REQ    ? (mem_gnt_i ? (mem_rvalid_i ? S_DONE : S_RESP) : S_REQ) :
               r_state == S_RESP   ? (mem_rvalid_i ? S_DONE : S_RESP) : S_IDLE;
   always_comb begin
      stall_o      = (r_state == S_IDLE && w_acc && !w_mis) || (w_busy && !w_to);
      mem_req_o    = r_state == S_REQ && !w_to;
      done_o       = r_state == S_DONE;
      misaligned_o = r_state == S_IDLE && w_acc && w_mis;
      fault_o      = w_to;
      load_data_o  = r_state == S_DONE ? r_load : '0;
   end
   assign mem_we_o    = r_we;
   assign mem_addr_o  = {r_addr[ADDR_W-1:2], 2'b00};
   assign mem_be_o    = r_be;
   assign mem_wdata_o = r_wdata;
   // Counter restarts on every state change, so entering REQ or RESP always begins at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr  <= '0;
         r_be    <= '0;
         r_wdata <= '0;
         r_we    <= 1'b0;
         r_f3    <= '0;
         r_cnt   <= '0;
         r_load  <= '0;
      end else begin
         if (r_state == S_IDLE && w_next == S_REQ) begin
            r_addr  <= addr_i;
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_we    <= mem_write_i;
            r_f3    <= funct3_i;
         end
         r_cnt <= (w_busy && w_next == r_state) ? r_cnt + 1'b1 : '0;
         if (w_busy && w_next == S_DONE) r_load <= w_ldata;
      end
   end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: table-driven access vectors with a done-time scoreboard, plus timeout and
// reset-while-waiting sequences.
module tb_lsu_ctrl;
   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] addr = '0, wdata = '0, rdata = '0;
   logic [2:0]  f3 = '0;
   logic        rd = 1'b0, wr = 1'b0, gnt = 1'b0, rvalid = 1'b0;
   logic        mem_req_o, mem_we_o, stall_o, done_o, misaligned_o, fault_o;
   logic [31:0] mem_addr_o, mem_wdata_o, load_data_o;
   logic [3:0]  mem_be_o;
   int n_cmp = 0, n_bad = 0;

   lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .addr_i(addr), .wdata_i(wdata), .funct3_i(f3),
      .mem_read_i(rd), .mem_write_i(wr), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata), .stall_o(stall_o),
      .load_data_o(load_data_o), .done_o(done_o), .misaligned_o(misaligned_o), .fault_o(fault_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic        rd, wr;
      logic [31:0] addr, wdata, rdata;
      int          gd, rv;
      logic [3:0]  be;
      logic        we;
      logic [31:0] exp_wd, exp_ld;
      logic        mis;
   } vec_t;

   vec_t vecs[14];
   vec_t sb[$];

   function automatic vec_t mk(input logic [2:0] f, input logic r, w, input logic [31:0] a, wd, rdt,
                               input int gd, rv, input logic [3:0] be, input logic we,
                               input logic [31:0] ewd, eld, input logic mis);
      vec_t v;
      v.f3 = f; v.rd = r; v.wr = w; v.addr = a; v.wdata = wd; v.rdata = rdt; v.gd = gd; v.rv = rv;
      v.be = be; v.we = we; v.exp_wd = ewd; v.exp_ld = eld; v.mis = mis;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run(input vec_t v);
      int gk, rk, stalls;
      bit seen;
      vec_t e;
      gk = v.gd + 1; rk = gk + v.rv; stalls = 0; seen = 0;
      @(negedge clk);
      addr = v.addr; wdata = v.wdata; f3 = v.f3; rd = v.rd; wr = v.wr; gnt = 0; rvalid = 0;
      #1;
      if (v.mis) begin
         chk("mis_pulse", 32'(misaligned_o), 1);
         chk("mis_stall", 32'(stall_o), 0);
         chk("mis_req", 32'(mem_req_o), 0);
         @(negedge clk); rd = 0; wr = 0; #1;
         chk("mis_noreq_after", 32'(mem_req_o), 0);
         chk("mis_clear", 32'(misaligned_o), 0);
         return;
      end
      stalls += 32'(stall_o);
      sb.push_back(v);
      for (int k = 1; k <= 20 && !seen; k++) begin
         @(negedge clk);
         rd = 0; wr = 0; gnt = (k == gk); rvalid = (k == rk); rdata = v.rdata;
         #1;
         stalls += 32'(stall_o);
         if (k == 1) begin
            chk("req_first", 32'(mem_req_o), 1);
            chk("be", 32'(mem_be_o), 32'(v.be));
            chk("addr", mem_addr_o, v.addr & 32'hFFFF_FFFC);
            chk("we", 32'(mem_we_o), 32'(v.we));
            chk("wdata", mem_wdata_o, v.exp_wd);
         end
         if (k == gk) begin
            chk("req_at_gnt", 32'(mem_req_o), 1);
            chk("wdata_hold", mem_wdata_o, v.exp_wd);
         end
         if (done_o) begin
            seen = 1;
            e = sb.pop_front();
            chk("done_cycle", k, rk + 1);
            if (!e.we) chk("load_data", load_data_o, e.exp_ld);
         end
      end
      if (!seen) chk("done_seen", 0, 1);
      chk("stall_cycles", stalls, rk + 1);
   endtask

   initial begin
      int reqs;
      bit flt;
      vecs[0]  = mk(3'b010, 1, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0, 4'b1111, 0, 0, 32'hDEADBEEF, 0);
      vecs[1]  = mk(3'b000, 1, 0, 32'h103, 0, 32'h80FF0000, 0, 0, 4'b1000, 0, 0, 32'hFFFFFF80, 0);
      vecs[2]  = mk(3'b100, 1, 0, 32'h103, 0, 32'h80FF0000, 0, 0, 4'b1000, 0, 0, 32'h00000080, 0);
      vecs[3]  = mk(3'b001, 0, 1, 32'h102, 32'h1234ABCD, 0, 3, 2, 4'b1100, 1, 32'hABCDABCD, 0, 0);
      vecs[4]  = mk(3'b010, 1, 0, 32'h101, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      vecs[5]  = mk(3'b001, 1, 0, 32'h102, 0, 32'h80017FFF, 0, 0, 4'b1100, 0, 0, 32'hFFFF8001, 0);
      vecs[6]  = mk(3'b101, 1, 0, 32'h100, 0, 32'h8001F00F, 1, 1, 4'b0011, 0, 0, 32'h0000F00F, 0);
      vecs[7]  = mk(3'b000, 0, 1, 32'h101, 32'h000000A5, 0, 0, 0, 4'b0010, 1, 32'hA5A5A5A5, 0, 0);
      vecs[8]  = mk(3'b010, 0, 1, 32'h104, 32'hCAFEF00D, 0, 0, 1, 4'b1111, 1, 32'hCAFEF00D, 0, 0);
      vecs[9]  = mk(3'b001, 1, 0, 32'h103, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      vecs[10] = mk(3'b011, 1, 0, 32'h108, 0, 32'h12345678, 0, 0, 4'b1111, 0, 0, 32'h12345678, 0);
      vecs[11] = mk(3'b010, 1, 1, 32'h10C, 32'h55AA55AA, 0, 0, 0, 4'b1111, 1, 32'h55AA55AA, 0, 0);
      vecs[12] = mk(3'b000, 1, 0, 32'h100, 0, 32'h0000007F, 0, 0, 4'b0001, 0, 0, 32'h0000007F, 0);
      vecs[13] = mk(3'b010, 0, 1, 32'h10A, 32'h11111111, 0, 0, 0, 0, 0, 0, 0, 1);

      repeat (2) @(posedge clk);
      @(negedge clk); rst = 0; #1;
      chk("rst_req", 32'(mem_req_o), 0);
      chk("rst_stall", 32'(stall_o), 0);
      chk("rst_done", 32'(done_o), 0);
      chk("rst_load", load_data_o, 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_fault", 32'(fault_o), 0);

      for (int i = 0; i < 14; i++) run(vecs[i]);

      // Grant never arrives: four request cycles, then the watchdog fires.
      @(negedge clk);
      addr = 32'h200; f3 = 3'b010; rd = 1; gnt = 0; rvalid = 0; #1;
      chk("to_issue_stall", 32'(stall_o), 1);
      reqs = 0; flt = 0;
      for (int k = 1; k <= 10 && !flt; k++) begin
         @(negedge clk); rd = 0; #1;
         if (fault_o) begin
            flt = 1;
            chk("to_req_cycles", reqs, 4);
            chk("to_stall", 32'(stall_o), 0);
            chk("to_req", 32'(mem_req_o), 0);
            chk("to_load", load_data_o, 0);
         end else reqs += 32'(mem_req_o);
      end
      if (!flt) chk("to_fault_seen", 0, 1);
      @(negedge clk); gnt = 1; rvalid = 1; #1;
      chk("to_fault_once", 32'(fault_o), 0);
      chk("to_idle_stall", 32'(stall_o), 0);
      chk("stray_done", 32'(done_o), 0);
      @(negedge clk); gnt = 0; rvalid = 0; #1;
      chk("stray_done_next", 32'(done_o), 0);

      // Reset while waiting for the response, then a late rvalid.
      @(negedge clk); addr = 32'h300; f3 = 3'b010; rd = 1;
      @(negedge clk); rd = 0; gnt = 1;
      @(negedge clk); gnt = 0; #1;
      chk("rr_resp_stall", 32'(stall_o), 1);
      chk("rr_resp_noreq", 32'(mem_req_o), 0);
      rst = 1;
      @(negedge clk); rst = 0; rvalid = 1; rdata = 32'hFFFFFFFF; #1;
      chk("rr_done", 32'(done_o), 0);
      chk("rr_stall", 32'(stall_o), 0);
      chk("rr_req", 32'(mem_req_o), 0);
      chk("rr_load", load_data_o, 0);
      chk("rr_fault", 32'(fault_o), 0);
      chk("rr_addr", mem_addr_o, 0);
      chk("rr_be", 32'(mem_be_o), 0);
      @(negedge clk); rvalid = 0; #1;
      chk("rr_done_next", 32'(done_o), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit directly downstream of the ALU. It consumes the ALU result as the effective address, plus rs2 store data and funct3.
- Drives a req/gnt/rvalid data-memory port with byte enables. Returns sign/zero-extended load data to the writeback mux.
- Holds the single-cycle core via stall_o until the access completes.
- Adds a timeout watchdog and misalignment detection.

Parameters:
- ADDR_W, 32, address width (equals DATA_WIDTH).
- DATA_W, 32, data width.
- TIMEOUT, 255, max cycles waiting for gnt or rvalid before an access-fault is declared. Must be ≥1.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- addr_i  in  ADDR_W  effective address (ALU result)
- wdata_i  in  DATA_W  store data (rs2)
- funct3_i  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- mem_read_i  in  1  load instruction present
- mem_write_i  in  1  store instruction present
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1=write
- mem_addr_o  out  ADDR_W  word-aligned address, addr_i with [1:0]=00
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  DATA_W  lane-shifted store data
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  response valid (load data or store ack)
- mem_rdata_i  in  DATA_W  raw read word
- stall_o  out  1  hold PC/instruction
- load_data_o  out  DATA_W  extended load result, valid while done_o=1
- done_o  out  1  access completes this cycle
- misaligned_o  out  1  one-cycle fault pulse
- fault_o  out  1  one-cycle timeout fault pulse

Behaviour:
- Reset: state IDLE. All outputs 0, including the timeout counter and the load_data register.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - If mem_read_i|mem_write_i and aligned → REQ, stall_o=1 in the same cycle (combinational from IDLE).
  - If misaligned (H with addr[0]=1; W with addr[1:0]≠0) → stay IDLE, misaligned_o=1 for that cycle, stall_o=0, no request.
  - mem_read_i and mem_write_i both high → treated as store.
- Request capture: address, be, shifted wdata, we and funct3 are registered on IDLE→REQ. Memory outputs come only from these registers and stay stable until gnt.
- REQ:
  - mem_req_o=1, stall_o=1.
  - On mem_gnt_i → RESP. mem_req_o drops the next cycle.
  - If mem_rvalid_i arrives in the same cycle as gnt → DONE directly.
- RESP:
  - mem_req_o=0, stall_o=1.
  - On mem_rvalid_i → DONE, capturing mem_rdata_i into the load register.
- DONE:
  - Exactly one cycle: done_o=1, stall_o=0, load_data_o valid.
  - Then → IDLE. The core advances the PC at this edge.
- Timeout:
  - Counter clears on entry to REQ and to RESP, and increments each cycle in REQ/RESP.
  - On reaching TIMEOUT: fault_o=1 for one cycle, → IDLE, stall_o=0 that cycle, mem_req_o=0, load_data_o=0.
- Byte enables: B/BU: 0001<<addr[1:0]; H/HU: 0011<<addr[1:0]; W: 1111.
- Store lanes: B replicates the byte into all 4 lanes; H replicates the halfword into both; W passes through.
- Load extraction: select the byte/half by the registered addr[1:0]. B/H sign-extend, BU/HU zero-extend, W passes through.
- Invalid funct3 (011, 110, 111): behaves as W.
- rst asserted in any state: → IDLE next edge. An outstanding request is abandoned and a late rvalid in IDLE is ignored.
- Stray gnt/rvalid in IDLE or DONE: ignored.
- Back-to-back accesses: a new access can start in the IDLE cycle immediately after DONE. Minimum access is 3 cycles (IDLE, REQ, DONE) with gnt and rvalid in the same cycle.

Decomposition:
- Shared package lsu_pkg:
  - state enum.
  - funct3 width codes LSU_B/H/W/BU/HU, matching the existing decoder macros.
  - be-generation function.
- One sub-module, lsu_align (combinational): be generation, store-lane replication, load extraction/extension.
- lsu_ctrl holds the FSM, capture registers and the timeout counter.

Test Plan:
- LW at addr 0x100 with gnt and rvalid same cycle as req, rdata=0xDEADBEEF → be=1111, stall high 2 cycles, done_o with load_data_o=0xDEADBEEF.
- LB at 0x103, rdata=0x80FF_0000 → be=1000, load_data_o=0xFFFFFF80. LBU same → 0x00000080.
- SH at 0x102, wdata=0x1234ABCD, gnt delayed 3 cycles, rvalid 2 later → be=1100, mem_wdata_o=0xABCDABCD held stable across the wait, done after the ack.
- LW at 0x101 → misaligned_o pulse, mem_req_o never asserts, stall_o=0.
- TIMEOUT=4, gnt never asserted → fault_o pulse after 4 REQ cycles, FSM in IDLE, load_data_o=0.
- rst asserted while in RESP, then a late rvalid in IDLE → all outputs 0, no done_o.
